// File: rtl/uparc_sysbus_arb_pkg.sv
// Shared encodings for the system-bus arbiter: FSM states, transfer owner
// and the default watchdog length.
package uparc_sysbus_arb_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [0:0] OWN_I = 1'b0;
   localparam logic [0:0] OWN_D = 1'b1;

   localparam int TMO_CYC_DEF = 255;

   // Width that can hold 0..tmo; kept at least 1 so a disabled watchdog still elaborates.
   function automatic int tmo_cnt_w(input int tmo);
      return (tmo > 0) ? $clog2(tmo + 1) : 1;
   endfunction

endpackage

// File: rtl/uparc_sysbus_req_slot.sv
// Single pending-request latch: captures a command pulse and holds it until
// the arbiter grants (clears) it.
module uparc_sysbus_req_slot #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_i,
   input  logic              clr_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              rnw_i,
   input  logic [BEN_W-1:0]  ben_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              vld_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              rnw_o,
   output logic [BEN_W-1:0]  ben_o,
   output logic [DATA_W-1:0] data_o
);

   logic              vld_q, vld_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rnw_q, rnw_d;
   logic [BEN_W-1:0]  ben_q, ben_d;
   logic [DATA_W-1:0] data_q, data_d;

   // Capture beats clear so a pulse landing on the grant cycle is not lost.
   always_comb begin
      vld_d  = vld_q;
      addr_d = addr_q;
      rnw_d  = rnw_q;
      ben_d  = ben_q;
      data_d = data_q;
      if (clr_i) vld_d = 1'b0;
      if (cap_i) begin
         vld_d  = 1'b1;
         addr_d = addr_i;
         rnw_d  = rnw_i;
         ben_d  = ben_i;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= 1'b0;
         addr_q <= '0;
         rnw_q  <= 1'b0;
         ben_q  <= '0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         addr_q <= addr_d;
         rnw_q  <= rnw_d;
         ben_q  <= ben_d;
         data_q <= data_d;
      end
   end

   // A second pulse while the first is still waiting overwrites it.
   always_ff @(posedge clk) begin
      if (!rst) assert (!(cap_i && vld_q && !clr_i));
   end

   assign vld_o  = vld_q;
   assign addr_o = addr_q;
   assign rnw_o  = rnw_q;
   assign ben_o  = ben_q;
   assign data_o = data_q;

endmodule

// File: rtl/uparc_sysbus_arb.sv
// Merges the CPU I-Port and D-Port onto one single-outstanding system bus with
// round-robin arbitration, response routing and a no-response watchdog.
//
// state   | meaning
// IDLE    | no transfer outstanding; grant a pending slot if any
// BUSY    | one transfer issued; waiting for slave Rdy/Err or watchdog expiry
module uparc_sysbus_arb
   import uparc_sysbus_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int BEN_W   = 4,
   parameter int TMO_CYC = TMO_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_IAddr,
   input  logic              i_IRdC,
   output logic [DATA_W-1:0] o_IData,
   output logic              o_IRdy,
   output logic              o_IErr,
   input  logic [ADDR_W-1:0] i_DAddr,
   input  logic              i_DCmd,
   input  logic              i_DRnW,
   input  logic [BEN_W-1:0]  i_DBen,
   input  logic [DATA_W-1:0] i_DData,
   output logic [DATA_W-1:0] o_DData,
   output logic              o_DRdy,
   output logic              o_DErr,
   output logic [ADDR_W-1:0] o_BAddr,
   output logic              o_BCmd,
   output logic              o_BRnW,
   output logic [BEN_W-1:0]  o_BBen,
   output logic [DATA_W-1:0] o_BData,
   input  logic [DATA_W-1:0] i_BData,
   input  logic              i_BRdy,
   input  logic              i_BErr
);

   localparam int CNT_W = tmo_cnt_w(TMO_CYC);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

   logic              i_vld, d_vld, i_rnw, d_rnw;
   logic [ADDR_W-1:0] i_addr, d_addr;
   logic [BEN_W-1:0]  i_ben, d_ben;
   logic [DATA_W-1:0] i_wdat, d_wdat;
   logic              grant_i, grant_d, tmo_hit;

   logic [0:0]        state_q, state_d, owner_q, owner_d, last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              b_cmd_q, b_cmd_d, b_rnw_q, b_rnw_d;
   logic [ADDR_W-1:0] b_addr_q, b_addr_d;
   logic [BEN_W-1:0]  b_ben_q, b_ben_d;
   logic [DATA_W-1:0] b_data_q, b_data_d;
   logic              i_rdy_q, i_rdy_d, i_err_q, i_err_d;
   logic              d_rdy_q, d_rdy_d, d_err_q, d_err_d;
   logic [DATA_W-1:0] i_data_q, i_data_d, d_data_q, d_data_d;

   uparc_sysbus_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEN_W(BEN_W)) u_slot_i (
      .clk(clk), .rst(rst), .cap_i(i_IRdC), .clr_i(grant_i),
      .addr_i(i_IAddr), .rnw_i(1'b1), .ben_i({BEN_W{1'b1}}), .data_i({DATA_W{1'b0}}),
      .vld_o(i_vld), .addr_o(i_addr), .rnw_o(i_rnw), .ben_o(i_ben), .data_o(i_wdat)
   );

   uparc_sysbus_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEN_W(BEN_W)) u_slot_d (
      .clk(clk), .rst(rst), .cap_i(i_DCmd), .clr_i(grant_d),
      .addr_i(i_DAddr), .rnw_i(i_DRnW), .ben_i(i_DBen), .data_i(i_DData),
      .vld_o(d_vld), .addr_o(d_addr), .rnw_o(d_rnw), .ben_o(d_ben), .data_o(d_wdat)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      b_cmd_d  = 1'b0;
      b_addr_d = b_addr_q;
      b_rnw_d  = b_rnw_q;
      b_ben_d  = b_ben_q;
      b_data_d = b_data_q;
      i_rdy_d  = 1'b0;
      i_err_d  = 1'b0;
      d_rdy_d  = 1'b0;
      d_err_d  = 1'b0;
      i_data_d = i_data_q;
      d_data_d = d_data_q;
      grant_i  = 1'b0;
      grant_d  = 1'b0;
      tmo_hit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_vld && d_vld) begin
               grant_d = (last_q == OWN_I);
               grant_i = !grant_d;
            end else begin
               grant_i = i_vld;
               grant_d = d_vld;
            end
            if (grant_i || grant_d) begin
               state_d  = ST_BUSY;
               owner_d  = grant_d ? OWN_D : OWN_I;
               last_d   = grant_d ? OWN_D : OWN_I;
               cnt_d    = '0;
               b_cmd_d  = 1'b1;
               b_addr_d = grant_d ? d_addr : i_addr;
               b_rnw_d  = grant_d ? d_rnw  : i_rnw;
               b_ben_d  = grant_d ? d_ben  : i_ben;
               b_data_d = grant_d ? d_wdat : i_wdat;
            end
         end
         default: begin
            tmo_hit = (TMO_CYC > 0) && (cnt_q == TMO_LAST);
            // A slave Rdy arriving on the expiry cycle still completes normally.
            if (i_BErr || (tmo_hit && !i_BRdy)) begin
               state_d = ST_IDLE;
               i_err_d = (owner_q == OWN_I);
               d_err_d = (owner_q == OWN_D);
            end else if (i_BRdy) begin
               state_d = ST_IDLE;
               if (owner_q == OWN_D) begin
                  d_rdy_d  = 1'b1;
                  d_data_d = i_BData;
               end else begin
                  i_rdy_d  = 1'b1;
                  i_data_d = i_BData;
               end
            end else if (TMO_CYC > 0) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         owner_q  <= OWN_I;
         last_q   <= OWN_I;
         cnt_q    <= '0;
         b_cmd_q  <= 1'b0;
         b_addr_q <= '0;
         b_rnw_q  <= 1'b0;
         b_ben_q  <= '0;
         b_data_q <= '0;
         i_rdy_q  <= 1'b0;
         i_err_q  <= 1'b0;
         d_rdy_q  <= 1'b0;
         d_err_q  <= 1'b0;
         i_data_q <= '0;
         d_data_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         b_cmd_q  <= b_cmd_d;
         b_addr_q <= b_addr_d;
         b_rnw_q  <= b_rnw_d;
         b_ben_q  <= b_ben_d;
         b_data_q <= b_data_d;
         i_rdy_q  <= i_rdy_d;
         i_err_q  <= i_err_d;
         d_rdy_q  <= d_rdy_d;
         d_err_q  <= d_err_d;
         i_data_q <= i_data_d;
         d_data_q <= d_data_d;
      end
   end

   assign o_BCmd  = b_cmd_q;
   assign o_BAddr = b_addr_q;
   assign o_BRnW  = b_rnw_q;
   assign o_BBen  = b_ben_q;
   assign o_BData = b_data_q;
   assign o_IRdy  = i_rdy_q;
   assign o_IErr  = i_err_q;
   assign o_IData = i_data_q;
   assign o_DRdy  = d_rdy_q;
   assign o_DErr  = d_err_q;
   assign o_DData = d_data_q;

endmodule

// File: tb/tb_uparc_sysbus_arb.sv
// Scoreboard bench for uparc_sysbus_arb: a transaction-level model predicts bus
// issues and port responses; two monitors check them as the DUT produces them.
module tb_uparc_sysbus_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_IAddr, i_DAddr, i_DData, i_BData;
   logic        i_IRdC, i_DCmd, i_DRnW, i_BRdy, i_BErr;
   logic [3:0]  i_DBen;
   logic [31:0] o_IData, o_DData, o_BAddr, o_BData;
   logic        o_IRdy, o_IErr, o_DRdy, o_DErr, o_BCmd, o_BRnW;
   logic [3:0]  o_BBen;

   uparc_sysbus_arb #(.ADDR_W(32), .DATA_W(32), .BEN_W(4), .TMO_CYC(8)) dut (
      .clk(clk), .rst(rst),
      .i_IAddr(i_IAddr), .i_IRdC(i_IRdC), .o_IData(o_IData), .o_IRdy(o_IRdy), .o_IErr(o_IErr),
      .i_DAddr(i_DAddr), .i_DCmd(i_DCmd), .i_DRnW(i_DRnW), .i_DBen(i_DBen), .i_DData(i_DData),
      .o_DData(o_DData), .o_DRdy(o_DRdy), .o_DErr(o_DErr),
      .o_BAddr(o_BAddr), .o_BCmd(o_BCmd), .o_BRnW(o_BRnW), .o_BBen(o_BBen), .o_BData(o_BData),
      .i_BData(i_BData), .i_BRdy(i_BRdy), .i_BErr(i_BErr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic        is_d;
      logic [31:0] addr;
      logic        rnw;
      logic [3:0]  ben;
      logic [31:0] data;
   } bus_exp_t;

   typedef struct {
      int          cyc;
      logic        is_d;
      logic        err;
      logic [31:0] idata;
      logic [31:0] ddata;
   } rsp_exp_t;

   bus_exp_t bq[$];
   rsp_exp_t rq[$];

   int checks = 0;
   int failures = 0;

   // Model state: which port won the last grant (1 = D) and each port's read-data output.
   logic        m_last_d;
   logic [31:0] m_idata, m_ddata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   always @(negedge clk) begin : bus_mon
      bus_exp_t b;
      if (o_BCmd) begin
         chk("bcmd_expected", 32'(bq.size() != 0), 32'd1);
         if (bq.size() != 0) begin
            b = bq.pop_front();
            chk("bcmd_cycle", cyc, b.cyc);
            chk("baddr", o_BAddr, b.addr);
            chk("brnw", {31'd0, o_BRnW}, {31'd0, b.rnw});
            chk("bben", {28'd0, o_BBen}, {28'd0, b.ben});
            if (b.is_d) chk("bdata", o_BData, b.data);
         end
      end
   end

   always @(negedge clk) begin : rsp_mon
      rsp_exp_t r;
      if (o_IRdy || o_IErr || o_DRdy || o_DErr) begin
         chk("rsp_expected", 32'(rq.size() != 0), 32'd1);
         if (rq.size() != 0) begin
            r = rq.pop_front();
            chk("rsp_cycle", cyc, r.cyc);
            chk("o_IRdy", {31'd0, o_IRdy}, {31'd0, !r.is_d && !r.err});
            chk("o_IErr", {31'd0, o_IErr}, {31'd0, !r.is_d && r.err});
            chk("o_DRdy", {31'd0, o_DRdy}, {31'd0, r.is_d && !r.err});
            chk("o_DErr", {31'd0, o_DErr}, {31'd0, r.is_d && r.err});
            chk("o_IData", o_IData, r.idata);
            chk("o_DData", o_DData, r.ddata);
         end
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // kind: 0=I only, 1=D only, 2=both in one cycle.
   // rsp: 0=Rdy, 1=Err, 2=Rdy+Err together, 3=no response (watchdog).
   task automatic run_scn(input int kind, input logic [31:0] ia, input logic [31:0] da,
                          input logic drnw, input logic [3:0] dben, input logic [31:0] dd,
                          input int lat0, input int lat1, input int rsp0, input int rsp1,
                          input logic [31:0] rd0, input logic [31:0] rd1, input logic late);
      logic        ord[2];
      int          lat[2], rsp[2];
      logic [31:0] rd[2];
      int          t, e, r, done, n, first_issue, late_c;
      bus_exp_t    be;
      rsp_exp_t    re;
      lat[0] = lat0; lat[1] = lat1;
      rsp[0] = rsp0; rsp[1] = rsp1;
      rd[0]  = rd0;  rd[1]  = rd1;
      if (kind == 2) begin
         n = 2; ord[0] = !m_last_d; ord[1] = m_last_d;
      end else begin
         n = 1; ord[0] = (kind == 1); ord[1] = 1'b0;
      end
      i_IRdC = (kind != 1); i_IAddr = ia;
      i_DCmd = (kind != 0); i_DAddr = da; i_DRnW = drnw; i_DBen = dben; i_DData = dd;
      t = cyc;
      @(negedge clk);
      i_IRdC = 1'b0; i_DCmd = 1'b0;
      i_IAddr = $urandom; i_DAddr = $urandom; i_DData = $urandom; i_DBen = 4'($urandom);
      i_DRnW = 1'($urandom);
      e = t + 2;
      first_issue = e;
      done = e;
      for (int j = 0; j < n; j++) begin
         m_last_d = ord[j];
         be.cyc  = e;
         be.is_d = ord[j];
         be.addr = ord[j] ? da : ia;
         be.rnw  = ord[j] ? drnw : 1'b1;
         be.ben  = ord[j] ? dben : 4'hF;
         be.data = dd;
         bq.push_back(be);
         re.is_d = ord[j];
         if (rsp[j] == 3) begin
            re.cyc = e + 8; re.err = 1'b1;
            re.idata = m_idata; re.ddata = m_ddata;
            rq.push_back(re);
            done = e + 8;
         end else begin
            r = e + lat[j];
            re.cyc = r + 1;
            re.err = (rsp[j] != 0);
            if (!re.err) begin
               if (ord[j]) m_ddata = rd[j]; else m_idata = rd[j];
            end
            re.idata = m_idata; re.ddata = m_ddata;
            rq.push_back(re);
            wait_cyc(r);
            i_BRdy = (rsp[j] != 1); i_BErr = (rsp[j] != 0); i_BData = rd[j];
            @(negedge clk);
            i_BRdy = 1'b0; i_BErr = 1'b0; i_BData = $urandom;
            done = r + 1;
         end
         e = done + 1;
      end
      late_c = 0;
      if (late) begin
         late_c = first_issue + 12;
         wait_cyc(late_c);
         i_BRdy = 1'b1; i_BData = $urandom;
         @(negedge clk);
         i_BRdy = 1'b0;
      end
      wait_cyc(((done > late_c) ? done : late_c) + 2);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
         i_BRdy = 1'($urandom); i_BErr = 1'($urandom); i_BData = $urandom;
         @(negedge clk);
         i_BRdy = 1'b0; i_BErr = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_BCmd"}, {31'd0, o_BCmd}, 32'd0);
      chk({tag, "_BAddr"}, o_BAddr, 32'd0);
      chk({tag, "_BRnW"}, {31'd0, o_BRnW}, 32'd0);
      chk({tag, "_BBen"}, {28'd0, o_BBen}, 32'd0);
      chk({tag, "_BData"}, o_BData, 32'd0);
      chk({tag, "_rdyerr"}, {28'd0, o_IRdy, o_IErr, o_DRdy, o_DErr}, 32'd0);
      chk({tag, "_IData"}, o_IData, 32'd0);
      chk({tag, "_DData"}, o_DData, 32'd0);
   endtask

   task automatic reset_mid_transfer();
      int t, e;
      bus_exp_t be;
      i_IRdC = 1'b1; i_IAddr = 32'h0000_0500;
      i_DCmd = 1'b1; i_DAddr = 32'h0000_6000; i_DRnW = 1'b0; i_DBen = 4'hC; i_DData = 32'hCAFE_0001;
      t = cyc;
      @(negedge clk);
      i_IRdC = 1'b0; i_DCmd = 1'b0;
      e = t + 2;
      be.cyc  = e;
      be.is_d = !m_last_d;
      be.addr = be.is_d ? 32'h0000_6000 : 32'h0000_0500;
      be.rnw  = be.is_d ? 1'b0 : 1'b1;
      be.ben  = be.is_d ? 4'hC : 4'hF;
      be.data = 32'hCAFE_0001;
      bq.push_back(be);
      wait_cyc(e + 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("rst_mid");
      m_last_d = 1'b0; m_idata = '0; m_ddata = '0;
      repeat (6) @(negedge clk);
      run_scn(0, 32'h0000_0700, 32'h0, 1'b1, 4'h0, 32'h0, 2, 0, 0, 0, 32'h7777_0000, 32'h0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout cycle=%0d", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      i_IAddr = '0; i_IRdC = 1'b0; i_DAddr = '0; i_DCmd = 1'b0; i_DRnW = 1'b0;
      i_DBen = '0; i_DData = '0; i_BData = '0; i_BRdy = 1'b0; i_BErr = 1'b0;
      m_last_d = 1'b0; m_idata = '0; m_ddata = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_scn(0, 32'h0000_0100, 32'h0, 1'b0, 4'h0, 32'h0, 3, 0, 0, 0, 32'hDEAD_BEEF, 32'h0, 1'b0);
      run_scn(2, 32'h0000_0100, 32'h0000_2000, 1'b0, 4'b0011, 32'h0000_1234,
              2, 2, 0, 0, 32'h1111_2222, 32'h3333_4444, 1'b0);
      for (int k = 0; k < 3; k++)
         run_scn(2, 32'h0000_0200 + 32'(k), 32'h0000_4000 + 32'(k), 1'b1, 4'hF, 32'h0,
                 1, 1, 0, 0, $urandom, $urandom, 1'b0);
      run_scn(1, 32'h0, 32'h0000_3000, 1'b1, 4'hF, 32'h0, 2, 0, 2, 0, 32'hBAD0_BAD0, 32'h0, 1'b0);
      run_scn(0, 32'h0000_0400, 32'h0, 1'b0, 4'h0, 32'h0, 0, 0, 3, 0, 32'h0, 32'h0, 1'b1);
      reset_mid_transfer();

      for (int k = 0; k < 40; k++) begin
         int kind, r0, r1;
         kind = int'($urandom_range(0, 2));
         r0 = int'($urandom_range(0, 11));
         r1 = int'($urandom_range(0, 11));
         r0 = (r0 <= 7) ? 0 : r0 - 7;
         r1 = (r1 <= 7) ? 0 : r1 - 7;
         if (r0 > 3) r0 = 3;
         if (r1 > 3) r1 = 3;
         run_scn(kind, $urandom, $urandom, 1'($urandom), 4'($urandom), $urandom,
                 int'($urandom_range(1, 7)), int'($urandom_range(1, 7)), r0, r1,
                 $urandom, $urandom, (kind != 2) && (r0 == 3));
      end

      repeat (12) @(negedge clk);
      chk("bus_q_left", 32'(bq.size()), 32'd0);
      chk("rsp_q_left", 32'(rq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
